// File: rtl/seven_seg_scan_driver.sv
// Binary-to-BCD (double dabble) converter feeding a time-multiplexed seven-seg digit scanner.
// Optional leading-zero blanking is compiled in with `define SEVEN_SEG_BLANK_EN.
module seven_seg_scan_driver #(
    parameter int WIDTH       = 12,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_value,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              conv_done,
    output logic              overflow,
    output logic [DIGITS-1:0] digit_sel,
    output logic [3:0]        digit_bcd
);
    localparam int CONV_DIGITS = (WIDTH * 3) / 10 + 1;
    localparam int SR_W        = 4 * CONV_DIGITS + WIDTH;
    localparam int PAD_DIGITS  = (DIGITS > CONV_DIGITS) ? DIGITS : CONV_DIGITS;
    localparam int CNT_W       = $clog2(WIDTH + 1);
    localparam int REF_W       = $clog2(REFRESH_DIV);
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                   state_reg, state_next;
    logic [SR_W-1:0]          sr_reg, sr_next, sr_adj;
    logic [CNT_W-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DIGITS-1:0][3:0]   disp_reg, disp_commit;
    logic                     overflow_reg;
    logic [4*PAD_DIGITS-1:0]  bcd_pad;
    logic                     ovf_hit;
    logic [REF_W-1:0]         refresh_cnt_reg, refresh_cnt_next;
    logic [IDX_W-1:0]         scan_idx_reg, scan_idx_next;
    logic                     refresh_wrap;
    logic [DIGITS-1:0]        digit_sel_reg, sel_next;
    logic [3:0]               digit_bcd_reg, bcd_next;

    // Add-3 correction on every BCD nibble before the shift; binary field passes through.
    assign sr_adj[WIDTH-1:0] = sr_reg[WIDTH-1:0];
    generate
        for (genvar gi = 0; gi < CONV_DIGITS; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = sr_reg[WIDTH + 4*gi +: 4];
            assign sr_adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*CONV_DIGITS-1:0] = sr_reg[SR_W-1:WIDTH];
    end

    always_comb begin
        ovf_hit = 1'b0;
        for (int i = DIGITS; i < PAD_DIGITS; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) ovf_hit = 1'b1;
        end
    end

    assign disp_commit = ovf_hit ? {DIGITS{4'd9}} : bcd_pad[4*DIGITS-1:0];

    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        bit_cnt_next = bit_cnt_reg;
        in_ready     = 1'b0;
        conv_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_next      = {{(4*CONV_DIGITS){1'b0}}, in_value};
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                sr_next      = sr_adj << 1;
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == CNT_W'(WIDTH - 1)) state_next = COMMIT;
            end
            COMMIT: begin
                conv_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SEVEN_SEG_BLANK_EN
    logic [DIGITS-1:0] blank_reg, blank_calc;
    logic              higher_zero;

    // A digit blanks only when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        blank_calc  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (bcd_pad[4*i +: 4] == 4'd0);
            blank_calc[i] = higher_zero && !ovf_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_reg <= '0;
        end else if (state_reg == COMMIT) begin
            blank_reg <= blank_calc;
        end
    end
`endif

    // Free-running scan, independent of the converter FSM.
    always_comb begin
        refresh_wrap     = (refresh_cnt_reg == REF_W'(REFRESH_DIV - 1));
        refresh_cnt_next = refresh_wrap ? '0 : refresh_cnt_reg + 1'b1;
        scan_idx_next    = scan_idx_reg;
        if (refresh_wrap) begin
            scan_idx_next = (scan_idx_reg == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
        end
        sel_next = ~(DIGITS'(1) << scan_idx_next);
        bcd_next = disp_reg[scan_idx_next];
`ifdef SEVEN_SEG_BLANK_EN
        if (blank_reg[scan_idx_next]) begin
            sel_next = '1;
            bcd_next = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            sr_reg          <= '0;
            bit_cnt_reg     <= '0;
            disp_reg        <= '0;
            overflow_reg    <= 1'b0;
            refresh_cnt_reg <= '0;
            scan_idx_reg    <= '0;
            digit_sel_reg   <= ~DIGITS'(1);
            digit_bcd_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            sr_reg          <= sr_next;
            bit_cnt_reg     <= bit_cnt_next;
            if (state_reg == COMMIT) begin
                disp_reg     <= disp_commit;
                overflow_reg <= ovf_hit;
            end
            refresh_cnt_reg <= refresh_cnt_next;
            scan_idx_reg    <= scan_idx_next;
            digit_sel_reg   <= sel_next;
            digit_bcd_reg   <= bcd_next;
        end
    end

    assign overflow  = overflow_reg;
    assign digit_sel = digit_sel_reg;
    assign digit_bcd = digit_bcd_reg;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: a 12-bit and a 16-bit instance, both 4 digits, fast scan.
module tb_seven_seg_scan_driver;
`ifdef SEVEN_SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] in_value_a = '0;
    logic        in_valid_a = 1'b0;
    logic        in_ready_a, conv_done_a, overflow_a;
    logic [3:0]  digit_sel_a, digit_bcd_a;
    logic [15:0] in_value_b = '0;
    logic        in_valid_b = 1'b0;
    logic        in_ready_b, conv_done_b, overflow_b;
    logic [3:0]  digit_sel_b, digit_bcd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.WIDTH(12), .DIGITS(4), .REFRESH_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .in_value(in_value_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .conv_done(conv_done_a), .overflow(overflow_a),
        .digit_sel(digit_sel_a), .digit_bcd(digit_bcd_a)
    );

    seven_seg_scan_driver #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .in_value(in_value_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .conv_done(conv_done_b), .overflow(overflow_b),
        .digit_sel(digit_sel_b), .digit_bcd(digit_bcd_b)
    );

    // Returns at the first cycle of digit 0's scan slot.
    task automatic sync_slot0(input bit inst, output bit found);
        logic [3:0] prev, cur;
        found = 1'b0;
        prev = inst ? digit_sel_b : digit_sel_a;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cur = inst ? digit_sel_b : digit_sel_a;
            if (cur == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = cur;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL scan_sync inst=%0d: digit 0 slot not seen within 40 cycles", inst);
        end
    endtask

    // Slot k of the scan lands in bits [4k+3:4k] of both outputs.
    task automatic read_digits(input bit inst, output logic [15:0] bcds, output logic [15:0] sels);
        bit found;
        bcds = '0;
        sels = '0;
        sync_slot0(inst, found);
        if (found) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) repeat (4) @(negedge clk);
                bcds[4*k +: 4] = inst ? digit_bcd_b : digit_bcd_a;
                sels[4*k +: 4] = inst ? digit_sel_b : digit_sel_a;
            end
        end
    endtask

    task automatic start(input bit inst, input logic [15:0] value);
        @(negedge clk);
        if (inst) begin in_value_b = value; in_valid_b = 1'b1; end
        else begin in_value_a = value[11:0]; in_valid_a = 1'b1; end
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit inst);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if ((inst ? in_ready_b : in_ready_a) === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle inst=%0d: in_ready not back within 40 cycles", inst);
        end
    endtask

    task automatic check_digits(input string name, input bit inst,
                                input logic [15:0] exp_bcds, input logic [15:0] exp_sels);
        logic [15:0] bcds, sels;
        read_digits(inst, bcds, sels);
        checks++;
        if (bcds !== exp_bcds) begin
            errors++;
            $display("FAIL %s_bcd got %h want %h", name, bcds, exp_bcds);
        end
        checks++;
        if (sels !== exp_sels) begin
            errors++;
            $display("FAIL %s_sel got %h want %h", name, sels, exp_sels);
        end
        $display("digits %s bcd=%h sel=%h", name, bcds, sels);
    endtask

    task automatic test_reset;
        bit done_seen = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready_a, conv_done_a, overflow_a, digit_sel_a, digit_bcd_a} !== {3'b100, 4'b1110, 4'h0}) begin
            errors++;
            $display("FAIL reset_a got rdy=%b done=%b ovf=%b sel=%b bcd=%h want 1 0 0 1110 0",
                     in_ready_a, conv_done_a, overflow_a, digit_sel_a, digit_bcd_a);
        end
        checks++;
        if ({in_ready_b, conv_done_b, overflow_b, digit_sel_b, digit_bcd_b} !== {3'b100, 4'b1110, 4'h0}) begin
            errors++;
            $display("FAIL reset_b got rdy=%b done=%b ovf=%b sel=%b bcd=%h want 1 0 0 1110 0",
                     in_ready_b, conv_done_b, overflow_b, digit_sel_b, digit_bcd_b);
        end
        reset = 1'b0;
        start(1'b0, 16'd1234);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (conv_done_a) done_seen = 1'b1;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (conv_done_a) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL reset_abandon got conv_done pulse want none");
        end
        checks++;
        if (in_ready_a !== 1'b1 || overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b ovf=%b want 1 0", in_ready_a, overflow_a);
        end
        check_digits("reset_display", 1'b0, 16'h0000, 16'h7BDE);
    endtask

    task automatic test_latency;
        @(negedge clk);
        in_value_a = 12'd1234;
        in_valid_a = 1'b1;
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL latency_accept got in_ready=%b want 1", in_ready_a);
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if (in_ready_a !== (c == 14) || conv_done_a !== (c == 13)) begin
                errors++;
                $display("FAIL latency c=N+%0d got rdy=%b done=%b want %b %b",
                         c, in_ready_a, conv_done_a, c == 14, c == 13);
            end
            @(negedge clk);
        end
        check_digits("latency_1234", 1'b0, 16'h1234, 16'h7BDE);
    endtask

    task automatic test_scan;
        bit found;
        logic [15:0] val = 16'h4095;
        logic [3:0]  exp_sel, exp_bcd;
        int k;
        start(1'b0, 16'd4095);
        wait_idle(1'b0);
        checks++;
        if (overflow_a !== 1'b0) begin
            errors++;
            $display("FAIL scan_overflow got %b want 0", overflow_a);
        end
        sync_slot0(1'b0, found);
        if (found) begin
            for (int c = 0; c < 20; c++) begin
                k = (c / 4) % 4;
                exp_sel = ~(4'b0001 << k);
                exp_bcd = val[4*k +: 4];
                checks++;
                if (digit_sel_a !== exp_sel || digit_bcd_a !== exp_bcd) begin
                    errors++;
                    $display("FAIL scan c=%0d got sel=%b bcd=%h want sel=%b bcd=%h",
                             c, digit_sel_a, digit_bcd_a, exp_sel, exp_bcd);
                end
                @(negedge clk);
            end
            $display("scan 4095 sequence walked over 20 cycles");
        end
    endtask

    task automatic test_overflow;
        start(1'b1, 16'd12345);
        wait_idle(1'b1);
        checks++;
        if (overflow_b !== 1'b1) begin
            errors++;
            $display("FAIL overflow_12345 got %b want 1", overflow_b);
        end
        check_digits("overflow_12345", 1'b1, 16'h9999, 16'h7BDE);
        start(1'b1, 16'd42);
        wait_idle(1'b1);
        checks++;
        if (overflow_b !== 1'b0) begin
            errors++;
            $display("FAIL overflow_42 got %b want 0", overflow_b);
        end
        check_digits("value_42", 1'b1, BLANK ? 16'hFF42 : 16'h0042, BLANK ? 16'hFFDE : 16'h7BDE);
    endtask

    task automatic test_back_to_back;
        int hits_mid = 0;
        int hits_late = 0;
        logic [3:0] exp_d0;
        logic exp_ready, exp_done;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c <= 44; c++) begin
            in_valid_a = (c <= 14);
            in_value_a = (c == 0 || c % 2 == 1) ? 12'd7 : 12'd8;
            exp_ready = (c == 0) || (c == 14) || (c >= 28);
            exp_done  = (c == 13) || (c == 27);
            checks++;
            if (in_ready_a !== exp_ready || conv_done_a !== exp_done) begin
                errors++;
                $display("FAIL b2b_hs c=%0d got rdy=%b done=%b want %b %b",
                         c, in_ready_a, conv_done_a, exp_ready, exp_done);
            end
            if (digit_sel_a == 4'b1110) begin
                exp_d0 = (c <= 14) ? 4'd0 : ((c <= 28) ? 4'd7 : 4'd8);
                if (c >= 15 && c <= 28) hits_mid++;
                if (c >= 29) hits_late++;
                checks++;
                if (digit_bcd_a !== exp_d0) begin
                    errors++;
                    $display("FAIL b2b_digit0 c=%0d got %h want %h", c, digit_bcd_a, exp_d0);
                end
            end
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        checks++;
        if (hits_mid == 0 || hits_late == 0) begin
            errors++;
            $display("FAIL b2b_coverage got mid=%0d late=%0d want both nonzero", hits_mid, hits_late);
        end
        $display("back_to_back committed 7 then 8 (digit0 hits %0d/%0d)", hits_mid, hits_late);
    endtask

    task automatic test_blanking;
        start(1'b0, 16'd7);
        wait_idle(1'b0);
        check_digits("blank_7", 1'b0, BLANK ? 16'hFFF7 : 16'h0007, BLANK ? 16'hFFFE : 16'h7BDE);
        start(1'b0, 16'd0);
        wait_idle(1'b0);
        check_digits("blank_0", 1'b0, BLANK ? 16'hFFF0 : 16'h0000, BLANK ? 16'hFFFE : 16'h7BDE);
        start(1'b0, 16'd1000);
        wait_idle(1'b0);
        check_digits("blank_1000", 1'b0, 16'h1000, 16'h7BDE);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_overflow();
        test_back_to_back();
        test_blanking();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
